sha256_compress_block: RTL and testbench

// - Iterative SHA-256 compression function: one 512-bit message block, one round per clock.
// - Adds the result to the incoming 256-bit chaining value and returns the updated hash.
// - Sits between the message padder/scheduler and the hash-state register. H_in is driven

---
 rtl/sha256_compress_block.sv | 169 ++++++++++++++++
 tb/tb_sha256_compress_block.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_compress_block.sv
// Iterative SHA-256 compression: one 512-bit block, one round per clock.
// The message schedule is expanded on the fly in a 16-word sliding window.
module sha256_compress_block (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] H_in,
  input  logic [511:0] M_in,
  input  logic         input_valid,
  output logic [255:0] H_out,
  output logic         output_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    big_s0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    big_s1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    small_s0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    small_s1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    unique case (idx)
      6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [5:0]         t_q, t_d;
  // Index 0 holds a / H0 / W[t]; index 7 holds h / H7.
  logic [7:0][31:0]   work_q, work_d;
  logic [7:0][31:0]   hin_q, hin_d;
  logic [15:0][31:0]  w_q, w_d;
  logic [255:0]       hout_q, hout_d;
  logic               ov_q, ov_d;

  logic [31:0]        t1, t2, w_new;

  // Round datapath and next schedule word, evaluated from current state.
  always_comb begin
    t1 = work_q[7] + big_s1(work_q[4]) + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6]))
       + k_rom(t_q) + w_q[0];
    t2 = big_s0(work_q[0])
       + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
    // W[t+16] from the window holding W[t..t+15].
    w_new = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_d  = work_q;
    hin_d   = hin_q;
    w_d     = w_q;
    hout_d  = hout_q;
    ov_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (input_valid) begin
          for (int i = 0; i < 8; i++) begin
            hin_d[i]  = H_in[255 - 32*i -: 32];
            work_d[i] = H_in[255 - 32*i -: 32];
          end
          for (int i = 0; i < 16; i++) begin
            w_d[i] = M_in[511 - 32*i -: 32];
          end
          t_d     = 6'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[7] = work_q[6];
        work_d[6] = work_q[5];
        work_d[5] = work_q[4];
        work_d[4] = work_q[3] + t1;
        work_d[3] = work_q[2];
        work_d[2] = work_q[1];
        work_d[1] = work_q[0];
        work_d[0] = t1 + t2;
        for (int i = 0; i < 15; i++) begin
          w_d[i] = w_q[i+1];
        end
        w_d[15] = w_new;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) begin
          state_d = StDone;
        end
      end
      StDone: begin
        for (int i = 0; i < 8; i++) begin
          hout_d[255 - 32*i -: 32] = hin_q[i] + work_q[i];
        end
        ov_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= 6'd0;
      work_q  <= '0;
      hin_q   <= '0;
      w_q     <= '0;
      hout_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      work_q  <= work_d;
      hin_q   <= hin_d;
      w_q     <= w_d;
      hout_q  <= hout_d;
      ov_q    <= ov_d;
    end
  end

  assign H_out        = hout_q;
  assign output_valid = ov_q;

endmodule

// File: tb/tb_sha256_compress_block.sv
// Self-checking bench for sha256_compress_block: scoreboard of expected digests,
// known FIPS 180-4 vectors plus a behavioural reference model for random blocks.
module tb_sha256_compress_block;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] H_in;
  logic [511:0] M_in;
  logic         input_valid;
  logic [255:0] H_out;
  logic         output_valid;

  sha256_compress_block dut (
    .clk          (clk),
    .rst          (rst),
    .H_in         (H_in),
    .M_in         (M_in),
    .input_valid  (input_valid),
    .H_out        (H_out),
    .output_valid (output_valid)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] Ihv =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] MsgAbc = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] MsgNull = {32'h80000000, 480'd0};
  localparam logic [511:0] MsgTwoA = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MsgTwoB = {480'd0, 32'h000001c0};
  localparam logic [255:0] ExpAbc =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ExpNull =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ExpTwo =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KTab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int prev_pulse_cyc = 0;
  int start_cyc = 0;
  logic [255:0] exp_q [$];
  string        tag_q [$];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [255:0] sha_model(input logic [255:0] hi, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      x1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      x2 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      w[i] = x1 + w[i-7] + x2 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hi[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KTab[t] + w[t];
      x2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hi[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output pulse pops and compares one expected digest.
  always @(negedge clk) begin
    if (!rst && output_valid) begin
      pulse_cnt++;
      prev_pulse_cyc = pulse_cyc;
      pulse_cyc = cyc;
      if (exp_q.size() == 0) check_eq("spurious_valid", {255'd0, output_valid}, 256'd0);
      else check_eq(tag_q.pop_front(), H_out, exp_q.pop_front());
    end
  end

  task automatic start_block(input logic [255:0] h, input logic [511:0] m,
                             input logic [255:0] e, input string tag);
    @(negedge clk);
    H_in = h;
    M_in = m;
    input_valid = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    start_cyc = cyc;
    @(negedge clk);
    input_valid = 1'b0;
    // Only the latched copies may matter from here on.
    H_in = rand_hash();
    M_in = rand_block();
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && pulse_cnt < target; i++) @(negedge clk);
    check_eq(tag, 256'(pulse_cnt), 256'(target));
  endtask

  initial begin
    logic [255:0] mid, hr;
    logic [511:0] mr;
    int p0;
    int seen;
    rst = 1'b1;
    input_valid = 1'b0;
    H_in = '0;
    M_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_hout", H_out, 256'd0);
    check_eq("rst_valid", {255'd0, output_valid}, 256'd0);
    rst = 1'b0;

    // "abc" single block, latency, pulse width and hold
    p0 = pulse_cnt;
    start_block(Ihv, MsgAbc, ExpAbc, "abc");
    wait_pulses("abc_done", p0 + 1, 80);
    check_eq("abc_latency", 256'(pulse_cyc - start_cyc), 256'd66);
    repeat (24) @(negedge clk);
    check_eq("abc_single_pulse", 256'(pulse_cnt - p0), 256'd1);
    check_eq("abc_hold", H_out, ExpAbc);
    check_eq("idle_valid_low", {255'd0, output_valid}, 256'd0);

    // Empty message
    p0 = pulse_cnt;
    start_block(Ihv, MsgNull, ExpNull, "null");
    wait_pulses("null_done", p0 + 1, 80);

    // Two-block message chained through the reference intermediate
    mid = sha_model(Ihv, MsgTwoA);
    p0 = pulse_cnt;
    start_block(Ihv, MsgTwoA, mid, "two_a");
    wait_pulses("two_a_done", p0 + 1, 80);
    start_block(mid, MsgTwoB, ExpTwo, "two_b");
    wait_pulses("two_b_done", p0 + 2, 80);

    // Start request during RUN must be ignored
    p0 = pulse_cnt;
    start_block(Ihv, MsgAbc, ExpAbc, "busy_abc");
    repeat (9) @(negedge clk);
    H_in = rand_hash();
    M_in = rand_block();
    input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    wait_pulses("busy_done", p0 + 1, 80);
    repeat (30) @(negedge clk);
    check_eq("busy_one_pulse", 256'(pulse_cnt - p0), 256'd1);

    // Reset mid-block abandons the block
    p0 = pulse_cnt;
    start_block(Ihv, MsgNull, ExpNull, "rst_abandoned");
    repeat (29) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    tag_q.delete();
    @(negedge clk);
    check_eq("rst_mid_hout", H_out, 256'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check_eq("rst_no_pulse", 256'(pulse_cnt - p0), 256'd0);
    check_eq("rst_hout_held", H_out, 256'd0);
    start_block(Ihv, MsgAbc, ExpAbc, "abc_after_rst");
    wait_pulses("abc_after_rst_done", p0 + 1, 80);

    // input_valid held high: back-to-back blocks, second uses inputs changed after E0
    p0 = pulse_cnt;
    @(negedge clk);
    H_in = Ihv;
    M_in = MsgNull;
    input_valid = 1'b1;
    exp_q.push_back(ExpNull);
    tag_q.push_back("b2b_first");
    exp_q.push_back(ExpAbc);
    tag_q.push_back("b2b_second");
    @(negedge clk);
    M_in = MsgAbc;
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (output_valid) seen++;
    end
    input_valid = 1'b0;
    repeat (80) @(negedge clk);
    check_eq("b2b_pulses", 256'(pulse_cnt - p0), 256'd2);
    check_eq("b2b_gap", 256'(pulse_cyc - prev_pulse_cyc), 256'd66);

    // Random chaining values and blocks against the reference model
    for (int k = 0; k < 3; k++) begin
      hr = rand_hash();
      mr = rand_block();
      p0 = pulse_cnt;
      start_block(hr, mr, sha_model(hr, mr), $sformatf("rand%0d", k));
      wait_pulses($sformatf("rand%0d_done", k), p0 + 1, 80);
    end

    repeat (5) @(negedge clk);
    check_eq("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
